// File: rtl/lu_pkg.sv
// rtl/lu_pkg.sv - shared types, state encodings and address helper for the LU row store
package lu_pkg;

  localparam int LU_SIZE = 16;
  localparam int LU_DW   = 64;

  typedef struct packed {
    logic [LU_DW-1:0] im;
    logic [LU_DW-1:0] re;
  } cplx_t;

  typedef cplx_t [LU_SIZE-1:0] row_t;

  typedef logic [1:0] store_state_t;
  localparam store_state_t IDLE  = 2'd0;
  localparam store_state_t LOAD  = 2'd1;
  localparam store_state_t SERVE = 2'd2;
  localparam store_state_t DRAIN = 2'd3;

  function automatic logic addr_in_range(input int unsigned addr, input int unsigned size);
    return addr < size;
  endfunction

endpackage

// File: rtl/lu_row_store_ram.sv
// rtl/lu_row_store_ram.sv - SIZE-row array, one write port, one registered read port
// A read that hits the row being written in the same cycle returns the new data.
module lu_row_store_ram
  import lu_pkg::*;
#(
  parameter int SIZE = LU_SIZE,
  parameter int DW   = LU_DW,
  parameter int AW   = $clog2(SIZE),
  parameter int RW   = SIZE * 2 * DW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [RW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [RW-1:0] rdata
);

  logic [RW-1:0] mem [SIZE];

  always_ff @(posedge clk_i) begin
    if (we && addr_in_range(32'(waddr), SIZE)) begin
      mem[waddr] <= wdata;
    end
  end

  // Out-of-range reads return zeros rather than whatever the index aliases to.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata <= '0;
    end else if (re) begin
      if (!addr_in_range(32'(raddr), SIZE)) begin
        rdata <= '0;
      end else if (we && (waddr == raddr)) begin
        rdata <= wdata;
      end else begin
        rdata <= mem[raddr];
      end
    end
  end

endmodule

// File: rtl/lu_row_store.sv
// rtl/lu_row_store.sv - working-matrix row store feeding the LU engine: load, serve, drain
// Optional read/write handshake counters are built when LU_ROW_STORE_PERF_EN is defined.
module lu_row_store
  import lu_pkg::*;
#(
  parameter int  SIZE = LU_SIZE,
  parameter int  DW   = LU_DW,
  localparam int AW   = $clog2(SIZE),
  localparam int RW   = SIZE * 2 * DW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic [RW-1:0] load_row_i,
  input  logic          load_valid_i,
  output logic          load_ready_o,
  output logic          lu_start_o,
  input  logic [AW-1:0] rd_addr_i,
  input  logic          rd_addr_valid_i,
  output logic [RW-1:0] rd_row_o,
  output logic [AW-1:0] rd_row_addr_o,
  output logic          rd_row_valid_o,
  input  logic [RW-1:0] wr_row_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  input  logic          factor_done_i,
  output logic [RW-1:0] dump_row_o,
  output logic [AW-1:0] dump_addr_o,
  output logic          dump_valid_o,
  input  logic          dump_ready_i,
  output logic          busy_o,
`ifdef LU_ROW_STORE_PERF_EN
  output logic [31:0]   perf_rd_o,
  output logic [31:0]   perf_wr_o,
`endif
  output logic          err_o
);

  store_state_t  state;
  logic [AW-1:0] load_cnt;
  logic [AW-1:0] drain_cnt;

  logic serve, load_fire, load_last, rd_fire, wr_fire, rd_ok, wr_ok;
  logic drain_fire, drain_last, drain_fetch;

  logic          ram_we, ram_re;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [RW-1:0] ram_wdata, ram_rdata;

  assign serve      = (state == SERVE);
  assign load_fire  = (state == LOAD) && load_valid_i;
  assign load_last  = (load_cnt == AW'(SIZE - 1));
  assign rd_fire    = serve && rd_addr_valid_i;
  assign wr_fire    = serve && wr_valid_i;
  assign rd_ok      = addr_in_range(32'(rd_addr_i), SIZE);
  assign wr_ok      = addr_in_range(32'(wr_addr_i), SIZE);
  assign drain_fire = (state == DRAIN) && dump_valid_o && dump_ready_i;
  assign drain_last = (drain_cnt == AW'(SIZE - 1));
  // Prefetch the next drain row on each accepted beat so rows stream without bubbles.
  assign drain_fetch = (state == DRAIN) && (!dump_valid_o || (drain_fire && !drain_last));

  assign ram_we    = !flush_i && (load_fire || (wr_fire && wr_ok));
  assign ram_waddr = load_fire ? load_cnt : wr_addr_i;
  assign ram_wdata = load_fire ? load_row_i : wr_row_i;
  assign ram_re    = !flush_i && (rd_fire || drain_fetch);
  assign ram_raddr = rd_fire    ? rd_addr_i :
                     drain_fire ? drain_cnt + AW'(1) : drain_cnt;

  lu_row_store_ram #(
    .SIZE (SIZE),
    .DW   (DW),
    .AW   (AW),
    .RW   (RW)
  ) u_ram (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign rd_row_o     = ram_rdata;
  assign dump_row_o   = ram_rdata;
  assign dump_addr_o  = drain_cnt;
  assign load_ready_o = (state == LOAD);
  assign wr_ready_o   = serve;
  assign busy_o       = (state != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      load_cnt       <= '0;
      drain_cnt      <= '0;
      lu_start_o     <= 1'b0;
      rd_row_valid_o <= 1'b0;
      rd_row_addr_o  <= '0;
      dump_valid_o   <= 1'b0;
      err_o          <= 1'b0;
    end else if (flush_i) begin
      state          <= IDLE;
      load_cnt       <= '0;
      drain_cnt      <= '0;
      lu_start_o     <= 1'b0;
      rd_row_valid_o <= 1'b0;
      rd_row_addr_o  <= '0;
      dump_valid_o   <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      lu_start_o     <= load_fire && load_last;
      rd_row_valid_o <= rd_fire;
      if (rd_fire) begin
        rd_row_addr_o <= rd_addr_i;
      end
      if ((!serve && (rd_addr_valid_i || wr_valid_i)) ||
          (rd_fire && !rd_ok) || (wr_fire && !wr_ok)) begin
        err_o <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (load_valid_i) begin
            state    <= LOAD;
            load_cnt <= '0;
          end
        end
        LOAD: begin
          if (load_valid_i) begin
            if (load_last) begin
              state    <= SERVE;
              load_cnt <= '0;
            end else begin
              load_cnt <= load_cnt + AW'(1);
            end
          end
        end
        SERVE: begin
          if (factor_done_i) begin
            state        <= DRAIN;
            drain_cnt    <= '0;
            dump_valid_o <= 1'b0;
          end
        end
        DRAIN: begin
          if (!dump_valid_o) begin
            dump_valid_o <= 1'b1;
          end else if (dump_ready_i) begin
            if (drain_last) begin
              state        <= IDLE;
              dump_valid_o <= 1'b0;
              drain_cnt    <= '0;
            end else begin
              drain_cnt <= drain_cnt + AW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LU_ROW_STORE_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_rd_o <= '0;
      perf_wr_o <= '0;
    end else if (flush_i || ((state == IDLE) && load_valid_i)) begin
      perf_rd_o <= '0;
      perf_wr_o <= '0;
    end else begin
      if (rd_fire && (perf_rd_o != '1)) perf_rd_o <= perf_rd_o + 32'd1;
      if (wr_fire && (perf_wr_o != '1)) perf_wr_o <= perf_wr_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lu_row_store.sv
// tb/tb_lu_row_store.sv - directed scoreboard bench for lu_row_store at SIZE=4
module tb_lu_row_store;

  localparam int SIZE = 4;
  localparam int DW   = 64;
  localparam int AW   = 2;
  localparam int RW   = SIZE * 2 * DW;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          flush_i = 1'b0;
  logic [RW-1:0] load_row_i = '0;
  logic          load_valid_i = 1'b0;
  logic          load_ready_o;
  logic          lu_start_o;
  logic [AW-1:0] rd_addr_i = '0;
  logic          rd_addr_valid_i = 1'b0;
  logic [RW-1:0] rd_row_o;
  logic [AW-1:0] rd_row_addr_o;
  logic          rd_row_valid_o;
  logic [RW-1:0] wr_row_i = '0;
  logic [AW-1:0] wr_addr_i = '0;
  logic          wr_valid_i = 1'b0;
  logic          wr_ready_o;
  logic          factor_done_i = 1'b0;
  logic [RW-1:0] dump_row_o;
  logic [AW-1:0] dump_addr_o;
  logic          dump_valid_o;
  logic          dump_ready_i = 1'b0;
  logic          busy_o;
  logic          err_o;

  always #5 clk_i = ~clk_i;

  lu_row_store #(.SIZE(SIZE), .DW(DW)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .load_row_i      (load_row_i),
    .load_valid_i    (load_valid_i),
    .load_ready_o    (load_ready_o),
    .lu_start_o      (lu_start_o),
    .rd_addr_i       (rd_addr_i),
    .rd_addr_valid_i (rd_addr_valid_i),
    .rd_row_o        (rd_row_o),
    .rd_row_addr_o   (rd_row_addr_o),
    .rd_row_valid_o  (rd_row_valid_o),
    .wr_row_i        (wr_row_i),
    .wr_addr_i       (wr_addr_i),
    .wr_valid_i      (wr_valid_i),
    .wr_ready_o      (wr_ready_o),
    .factor_done_i   (factor_done_i),
    .dump_row_o      (dump_row_o),
    .dump_addr_o     (dump_addr_o),
    .dump_valid_o    (dump_valid_o),
    .dump_ready_i    (dump_ready_i),
    .busy_o          (busy_o),
    .err_o           (err_o)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [RW-1:0] d;
  } exp_t;

  exp_t          rd_q[$];
  logic [RW-1:0] model [SIZE];
  int            n_checks = 0;
  int            n_fail = 0;

  function automatic logic [RW-1:0] make_row(input int r, input logic inv);
    logic [RW-1:0] v;
    for (int k = 0; k < SIZE; k++) v[k*2*DW +: 2*DW] = {DW'(r), DW'(k)};
    return inv ? ~v : v;
  endfunction

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and score any read result the DUT presents.
  task automatic tick();
    exp_t e;
    @(posedge clk_i);
    #1;
    if (rd_row_valid_o) begin
      n_checks++;
      assert (rd_q.size() != 0) else begin
        n_fail++;
        $error("FAIL rd_unexpected observed=valid expected=no read pending");
      end
      if (rd_q.size() != 0) begin
        e = rd_q.pop_front();
        chk32("rd_addr", 32'(rd_row_addr_o), 32'(e.a));
        chk("rd_row", rd_row_o, e.d);
      end
    end
  endtask

  task automatic read(input int a);
    exp_t e;
    rd_addr_i       = AW'(a);
    rd_addr_valid_i = 1'b1;
    e.a = AW'(a);
    e.d = model[a];
    rd_q.push_back(e);
  endtask

  task automatic do_load(input logic inv);
    int   r = 0;
    int   starts = 0;
    logic hs;
    load_valid_i = 1'b1;
    for (int c = 0; c < 20 && r < SIZE; c++) begin
      load_row_i = make_row(r, inv);
      hs = load_ready_o;
      tick();
      if (hs) begin
        model[r] = make_row(r, inv);
        r++;
      end
      if (lu_start_o) starts++;
    end
    chk32("load_rows", 32'(r), 32'(SIZE));
    chk32("lu_start_after_last", 32'(lu_start_o), 32'd1);
    load_valid_i = 1'b0;
    tick();
    if (lu_start_o) starts++;
    chk32("lu_start_once", 32'(starts), 32'd1);
    chk32("serve_wr_ready", 32'(wr_ready_o), 32'd1);
    chk32("serve_load_ready", 32'(load_ready_o), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk32({tag, "_load_ready"}, 32'(load_ready_o), 32'd0);
    chk32({tag, "_lu_start"}, 32'(lu_start_o), 32'd0);
    chk32({tag, "_rd_valid"}, 32'(rd_row_valid_o), 32'd0);
    chk32({tag, "_rd_addr"}, 32'(rd_row_addr_o), 32'd0);
    chk32({tag, "_wr_ready"}, 32'(wr_ready_o), 32'd0);
    chk32({tag, "_dump_valid"}, 32'(dump_valid_o), 32'd0);
    chk32({tag, "_dump_addr"}, 32'(dump_addr_o), 32'd0);
    chk32({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk32({tag, "_err"}, 32'(err_o), 32'd0);
    chk({tag, "_rd_row"}, rd_row_o, '0);
    chk({tag, "_dump_row"}, dump_row_o, '0);
  endtask

  initial begin
    int            idx;
    logic          hs;
    int            r;
    logic [127:0]  el;

    #2;
    chk_all_zero("reset");
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    chk_all_zero("post_reset");

    // Load {im=r, re=k}
    do_load(1'b0);

    // Single read, then back-to-back reads
    read(2);
    tick();
    el = rd_row_o[3*2*DW +: 2*DW];
    chk("rd2_elem3", {{(RW-128){1'b0}}, el}, {{(RW-128){1'b0}}, 64'd2, 64'd3});
    chk32("rd2_addr_echo", 32'(rd_row_addr_o), 32'd2);
    read(0);
    tick();
    read(1);
    tick();
    read(3);
    tick();
    rd_addr_valid_i = 1'b0;
    tick();
    chk32("b2b_queue_empty", 32'(rd_q.size()), 32'd0);

    // Same-cycle write/read to row 1
    wr_valid_i = 1'b1;
    wr_addr_i  = 2'd1;
    wr_row_i   = '1;
    model[1]   = '1;
    read(1);
    tick();
    wr_valid_i = 1'b0;
    read(1);
    tick();
    rd_addr_valid_i = 1'b0;
    tick();
    chk32("bypass_queue_empty", 32'(rd_q.size()), 32'd0);
    chk32("serve_err", 32'(err_o), 32'd0);

    // Drain with ready toggling 1,0,1,...
    factor_done_i = 1'b1;
    tick();
    factor_done_i = 1'b0;
    idx = 0;
    for (int c = 0; c < 40 && idx < SIZE; c++) begin
      dump_ready_i = (c % 2 == 0);
      if (dump_valid_o) begin
        chk32("dump_addr", 32'(dump_addr_o), 32'(idx));
        chk("dump_row", dump_row_o, model[idx]);
      end
      hs = dump_valid_o && dump_ready_i;
      tick();
      if (hs) idx++;
    end
    dump_ready_i = 1'b0;
    chk32("drain_rows", 32'(idx), 32'(SIZE));
    chk32("busy_after_drain", 32'(busy_o), 32'd0);
    chk32("dump_valid_after_drain", 32'(dump_valid_o), 32'd0);

    // Reset after two load beats
    r = 0;
    load_valid_i = 1'b1;
    for (int c = 0; c < 10 && r < 2; c++) begin
      load_row_i = make_row(r + 8, 1'b0);
      hs = load_ready_o;
      tick();
      if (hs) r++;
    end
    chk32("partial_rows", 32'(r), 32'd2);
    rst_i = 1'b1;
    load_valid_i = 1'b0;
    #2;
    chk_all_zero("mid_reset");
    tick();
    rst_i = 1'b0;
    tick();
    do_load(1'b1);
    for (int a = 0; a < SIZE; a++) begin
      read(a);
      tick();
    end
    rd_addr_valid_i = 1'b0;
    tick();
    chk32("reload_queue_empty", 32'(rd_q.size()), 32'd0);

    // Protocol error in LOAD, cleared by flush
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk32("flush_busy", 32'(busy_o), 32'd0);
    load_valid_i = 1'b1;
    tick();
    load_valid_i = 1'b0;
    chk32("load_state", 32'(load_ready_o), 32'd1);
    chk32("err_before", 32'(err_o), 32'd0);
    wr_valid_i = 1'b1;
    tick();
    wr_valid_i = 1'b0;
    chk32("err_wr_in_load", 32'(err_o), 32'd1);
    chk32("wr_ready_in_load", 32'(wr_ready_o), 32'd0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk32("err_after_flush", 32'(err_o), 32'd0);
    chk32("busy_after_flush", 32'(busy_o), 32'd0);
    chk32("load_ready_after_flush", 32'(load_ready_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
